wb_interconnect_n: RTL and testbench

WB_INTERCONNECT_N -- requirements
Module: wb_interconnect_n

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_addr_decoder.sv | 27 ++
 rtl/wb_interconnect_n.sv | 157 +++++++++++++++
 tb/tb_wb_interconnect_n.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types, default address map and helpers for the Wishbone interconnect
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Default map for four 32-bit slaves, slice i = slave i (slave 0 in the low bits).
    // Slave 0: 0x3xxx_xxxx, slave 1: 0x2000_0xxx, slaves 2/3 unmapped (mask 0).
    localparam logic [127:0] DEF_SLV_BASE = {32'h0000_0000, 32'h0000_0000,
                                             32'h2000_0000, 32'h3000_0000};
    localparam logic [127:0] DEF_SLV_MASK = {32'h0000_0000, 32'h0000_0000,
                                             32'hFFFF_F000, 32'hF000_0000};

    function automatic int wb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// rtl/wb_addr_decoder.sv - combinational base/mask address decoder, lowest matching slave wins
module wb_addr_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLV    = 4,
    parameter int IDX_W      = 2,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    // Scan from the top index down so the lowest matching slave is the last writer
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_interconnect_n.sv
// rtl/wb_interconnect_n.sv - single-master Wishbone interconnect to NUM_SLV decoded slaves with timeout
module wb_interconnect_n
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int TIMEOUT    = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [ADDR_WIDTH-1:0]               M_ADR_O,
    input  logic [DATA_WIDTH-1:0]               M_DAT_O,
    input  logic                                M_WE_O,
    input  logic [DATA_WIDTH/8-1:0]             M_SEL_O,
    input  logic                                M_STB_O,
    input  logic                                M_CYC_O,
    output logic [DATA_WIDTH-1:0]               M_DAT_I,
    output logic                                M_ACK_I,
    output logic                                M_ERR_I,
    output logic [NUM_SLV*DATA_WIDTH-1:0]       S_DAT_I,
    output logic [NUM_SLV*ADDR_WIDTH-1:0]       S_ADR_I,
    output logic [NUM_SLV-1:0]                  S_WE_I,
    output logic [NUM_SLV*(DATA_WIDTH/8)-1:0]   S_SEL_I,
    output logic [NUM_SLV-1:0]                  S_STB_I,
    output logic [NUM_SLV-1:0]                  S_CYC_I,
    input  logic [NUM_SLV*DATA_WIDTH-1:0]       S_DAT_O,
    input  logic [NUM_SLV-1:0]                  S_ACK_O,
    input  logic [NUM_SLV-1:0]                  S_ERR_O,
    output logic                                busy_o
);

    localparam int  SEL_W  = DATA_WIDTH / 8;
    localparam int  IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int  CNT_W  = wb_max(8, $clog2(TIMEOUT + 1));
    localparam bit  TMO_EN = (TIMEOUT != 0);

    state_t           r_ps;
    state_t           w_ns;
    logic [IDX_W-1:0] r_sel_q;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    int               w_sel_i;
    logic             w_req;
    logic             w_sel_ack;
    logic             w_sel_err;
    logic             w_timeout;

    wb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLV    (NUM_SLV),
        .IDX_W      (IDX_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .addr (M_ADR_O),
        .hit  (w_hit),
        .idx  (w_idx)
    );

    assign w_sel_i   = int'(r_sel_q);
    assign w_req     = M_STB_O & M_CYC_O;
    assign w_sel_ack = S_ACK_O[w_sel_i];
    assign w_sel_err = S_ERR_O[w_sel_i];
    assign w_timeout = TMO_EN && (r_cnt == CNT_W'(TIMEOUT)) && !w_sel_ack && !w_sel_err;

    // State, selected slave and BUSY-cycle counter; the counter restarts on every IDLE cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ps    <= IDLE;
            r_sel_q <= '0;
            r_cnt   <= '0;
        end else begin
            r_ps <= w_ns;
            if (r_ps == IDLE) begin
                r_cnt <= '0;
                if (w_req && w_hit) begin
                    r_sel_q <= w_idx;
                end
            end else if (r_ps == BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and all routed outputs; everything is held at zero while reset is asserted
    always_comb begin
        w_ns    = r_ps;
        M_DAT_I = '0;
        M_ACK_I = 1'b0;
        M_ERR_I = 1'b0;
        S_DAT_I = '0;
        S_ADR_I = '0;
        S_WE_I  = '0;
        S_SEL_I = '0;
        S_STB_I = '0;
        S_CYC_I = '0;
        busy_o  = 1'b0;

        case (r_ps)
            IDLE: begin
                if (w_req) begin
                    w_ns = w_hit ? BUSY : ERR;
                end
            end
            BUSY: begin
                S_ADR_I[w_sel_i*ADDR_WIDTH +: ADDR_WIDTH] = M_ADR_O;
                S_DAT_I[w_sel_i*DATA_WIDTH +: DATA_WIDTH] = M_DAT_O;
                S_SEL_I[w_sel_i*SEL_W +: SEL_W]           = M_SEL_O;
                S_WE_I[w_sel_i]                           = M_WE_O;
                if (!M_CYC_O) begin
                    // Master abandoned the cycle: drop it silently
                    w_ns = IDLE;
                end else if (w_timeout) begin
                    M_ERR_I = 1'b1;
                    w_ns    = IDLE;
                end else begin
                    S_STB_I[w_sel_i] = M_STB_O;
                    S_CYC_I[w_sel_i] = 1'b1;
                    M_DAT_I = S_DAT_O[w_sel_i*DATA_WIDTH +: DATA_WIDTH];
                    M_ACK_I = w_sel_ack;
                    M_ERR_I = w_sel_err;
                    if (w_sel_ack || w_sel_err) begin
                        w_ns = IDLE;
                    end
                end
            end
            ERR: begin
                M_ERR_I = 1'b1;
                w_ns    = IDLE;
            end
            default: begin
                w_ns = IDLE;
            end
        endcase

        busy_o = (r_ps != IDLE);

        if (rst_i) begin
            M_DAT_I = '0;
            M_ACK_I = 1'b0;
            M_ERR_I = 1'b0;
            S_DAT_I = '0;
            S_ADR_I = '0;
            S_WE_I  = '0;
            S_SEL_I = '0;
            S_STB_I = '0;
            S_CYC_I = '0;
            busy_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_interconnect_n.sv
// tb/tb_wb_interconnect_n.sv - randomized self-checking bench for wb_interconnect_n
module tb_wb_interconnect_n;

    localparam int TMO = 255;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  M_ADR_O, M_DAT_O;
    logic         M_WE_O, M_STB_O, M_CYC_O;
    logic [3:0]   M_SEL_O;
    logic [31:0]  M_DAT_I;
    logic         M_ACK_I, M_ERR_I;
    logic [127:0] S_DAT_I, S_ADR_I, S_DAT_O;
    logic [3:0]   S_WE_I, S_STB_I, S_CYC_I, S_ACK_O, S_ERR_O;
    logic [15:0]  S_SEL_I;
    logic         busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    wb_interconnect_n #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .M_ADR_O(M_ADR_O), .M_DAT_O(M_DAT_O), .M_WE_O(M_WE_O), .M_SEL_O(M_SEL_O),
        .M_STB_O(M_STB_O), .M_CYC_O(M_CYC_O),
        .M_DAT_I(M_DAT_I), .M_ACK_I(M_ACK_I), .M_ERR_I(M_ERR_I),
        .S_DAT_I(S_DAT_I), .S_ADR_I(S_ADR_I), .S_WE_I(S_WE_I), .S_SEL_I(S_SEL_I),
        .S_STB_I(S_STB_I), .S_CYC_I(S_CYC_I),
        .S_DAT_O(S_DAT_O), .S_ACK_O(S_ACK_O), .S_ERR_O(S_ERR_O),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Address map from the block's defaults, evaluated directly from base/mask rules
    function automatic void ref_decode(input logic [31:0] a, output bit hit, output int tgt);
        logic [31:0] base [4];
        logic [31:0] mask [4];
        base = '{32'h3000_0000, 32'h2000_0000, 32'h0, 32'h0};
        mask = '{32'hF000_0000, 32'hFFFF_F000, 32'h0, 32'h0};
        hit = 1'b0;
        tgt = 0;
        for (int i = 0; i < 4; i++) begin
            if (!hit && mask[i] != 0 && (a & mask[i]) == base[i]) begin
                hit = 1'b1;
                tgt = i;
            end
        end
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {busy_o, M_ACK_I, M_ERR_I, S_STB_I, S_CYC_I, S_WE_I}, '0);
        check({tag, "_mdat"}, M_DAT_I, '0);
        check({tag, "_sbus"}, S_ADR_I | S_DAT_I | {112'd0, S_SEL_I}, '0);
    endtask

    // mode: 0 normal (ack after lat cycles), 1 slave silent -> timeout,
    //       2 master drops CYC in BUSY cycle 3, 3 reset pulsed in BUSY cycle 2
    // rtype: 0 ack, 1 err, 2 ack+err together
    task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] sel, input int lat, input int mode,
                           input int rtype, input bit fix_sd, input logic [31:0] fixed_sd);
        bit          hit;
        int          tgt;
        bit          done;
        bit          resp;
        logic [31:0] sd;
        ref_decode(a, hit, tgt);

        @(posedge clk_i); #1;
        M_ADR_O = a; M_DAT_O = d; M_WE_O = we; M_SEL_O = sel; M_STB_O = 1'b1; M_CYC_O = 1'b1;
        @(negedge clk_i);
        check_quiet("req_idle");

        if (!hit) begin
            @(posedge clk_i); #1;
            S_ACK_O = 4'($urandom); S_ERR_O = 4'($urandom);
            @(negedge clk_i);
            check("unmapped_resp", {busy_o, M_ACK_I, M_ERR_I}, 3'b101);
            check("unmapped_dat", M_DAT_I, '0);
            check("unmapped_nostb", {S_STB_I, S_CYC_I}, '0);
        end else begin
            done = 1'b0;
            for (int k = 1; k <= TMO + 4 && !done; k++) begin
                @(posedge clk_i); #1;
                sd = fix_sd ? fixed_sd : $urandom;
                S_DAT_O = {$urandom, $urandom, $urandom, $urandom};
                S_DAT_O[tgt*32 +: 32] = sd;
                S_ACK_O = 4'($urandom) & ~(4'b1 << tgt);
                S_ERR_O = 4'($urandom) & ~(4'b1 << tgt);
                resp = (mode == 0) && (k == lat + 1);
                if (resp && rtype != 1) S_ACK_O[tgt] = 1'b1;
                if (resp && rtype != 0) S_ERR_O[tgt] = 1'b1;
                if (mode == 2 && k == 3) begin
                    M_CYC_O = 1'b0; M_STB_O = 1'b0; S_ACK_O[tgt] = 1'b1;
                end
                if (mode == 3 && k == 2) rst_i = 1'b1;
                @(negedge clk_i);
                if (mode == 3 && k == 2) begin
                    check_quiet("rst_busy");
                    done = 1'b1;
                end else if (mode == 2 && k == 3) begin
                    check("abort_resp", {busy_o, M_ACK_I, M_ERR_I}, 3'b100);
                    check("abort_stb", {S_STB_I, S_CYC_I}, '0);
                    done = 1'b1;
                end else if (mode == 1 && k == TMO + 1) begin
                    check("tmo_resp", {busy_o, M_ACK_I, M_ERR_I}, 3'b101);
                    check("tmo_stb", {S_STB_I, S_CYC_I}, '0);
                    done = 1'b1;
                end else begin
                    check("busy_strobe", {busy_o, S_STB_I, S_CYC_I},
                          {1'b1, 4'b1 << tgt, 4'b1 << tgt});
                    check("busy_route", {S_ADR_I, S_DAT_I},
                          {128'(a) << (32 * tgt), 128'(d) << (32 * tgt)});
                    check("busy_selwe", {S_SEL_I, S_WE_I},
                          {16'(sel) << (4 * tgt), 4'(we) << tgt});
                    check("busy_mresp", {M_ACK_I, M_ERR_I},
                          {resp && rtype != 1, resp && rtype != 0});
                    if (resp) check("busy_mdat", M_DAT_I, sd);
                    done = resp;
                end
            end
            if (!done) check("txn_end", 1'b0, 1'b1);
        end

        @(posedge clk_i); #1;
        M_STB_O = 1'b0; M_CYC_O = 1'b0; M_WE_O = 1'b0; M_SEL_O = '0;
        S_ERR_O = '0;
        S_ACK_O = (mode == 2) ? (4'b1 << tgt) : 4'b0;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_quiet("after_txn");
        @(posedge clk_i); #1;
        S_ACK_O = '0;
    endtask

    initial begin
        rst_i = 1'b1;
        M_ADR_O = '0; M_DAT_O = '0; M_WE_O = 1'b0; M_SEL_O = '0; M_STB_O = 1'b0; M_CYC_O = 1'b0;
        S_DAT_O = '0; S_ACK_O = '0; S_ERR_O = '0;
        @(negedge clk_i);
        check_quiet("in_reset");
        // Reset holds even while the master requests
        M_ADR_O = 32'h3000_0000; M_STB_O = 1'b1; M_CYC_O = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_quiet("reset_req");
        @(posedge clk_i); #1;
        rst_i = 1'b0; M_STB_O = 1'b0; M_CYC_O = 1'b0;
        @(negedge clk_i);
        check_quiet("post_reset");

        // Directed scenarios
        run_txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, 2, 0, 0, 1'b1, 32'hDEAD_BEEF);
        run_txn(32'h2000_0004, 1'b1, 32'h55, 4'b0001, 0, 0, 0, 1'b0, 32'h0);
        run_txn(32'h1000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 0, 1'b0, 32'h0);
        run_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 1, 0, 1'b0, 32'h0);
        run_txn(32'h3000_0020, 1'b0, 32'h0, 4'hF, 0, 2, 0, 1'b0, 32'h0);
        run_txn(32'h3000_0030, 1'b1, 32'h1234, 4'hF, 0, 3, 0, 1'b0, 32'h0);
        run_txn(32'h3000_0040, 1'b0, 32'h0, 4'hF, 1, 0, 0, 1'b1, 32'hCAFE_F00D);
        run_txn(32'h2000_0FFC, 1'b0, 32'h0, 4'hF, 3, 0, 2, 1'b0, 32'h0);
        run_txn(32'h2000_1000, 1'b0, 32'h0, 4'hF, 0, 0, 0, 1'b0, 32'h0);

        // Randomized traffic across mapped, near-miss and arbitrary addresses
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          cls;
            int          mode;
            cls = $urandom_range(0, 3);
            case (cls)
                0:       a = {4'h3, 28'($urandom)};
                1:       a = {20'h20000, 12'($urandom)};
                2:       a = {20'h20000 | 20'($urandom_range(1, 15)), 12'($urandom)};
                default: a = $urandom;
            endcase
            mode = ($urandom_range(0, 9) == 0) ? 2 : 0;
            run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 6), mode,
                    $urandom_range(0, 2), 1'b0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
